audio_stream_sequencer: RTL and testbench
=========================================

Name: audio_stream_sequencer

Overview:
- Sequences one stereo sample at a time between the codec FIFO interface (available/read/allowed/write strobes) and the effect chain.
- Pops the input FIFO, hands the sample to the effect pipeline over a valid/ready handshake, and collects the processed result. It then writes the result to the output FIFO once space is available.
- Provides bypass, a watchdog that falls back to the dry sample if the effect chain stalls, and status counters.
- Sits between the audio controller core and the effects top.

Parameters:
DATA_W, 32, sample width per channel
TIMEOUT_CYCLES, 1024, watchdog limit in cycles for the effect handshake (range 2..65535)
CNT_W, 16, width of the status counters

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  permits starting a new sample; sampled only in IDLE
bypass  in  1  skip the effect chain; sampled in POP
audio_in_available  in  1  input FIFO non-empty; data is valid while high
audio_in_L / audio_in_R  in  DATA_W  FIFO head samples
read_audio_in  out  1  one-cycle pop strobe
audio_out_allowed  in  1  output FIFO has space
write_audio_out  out  1  one-cycle push strobe
audio_out_L / audio_out_R  out  DATA_W  samples to push
fx_in_valid  out  1  sample offered to the effect chain
fx_in_ready  in  1  effect chain accepts the sample
fx_in_L / fx_in_R  out  DATA_W  dry sample to the effect chain
fx_out_valid  in  1  processed sample available
fx_out_ready  out  1  sequencer accepts the processed sample
fx_out_L / fx_out_R  in  DATA_W  processed sample
fx_flush  out  1  one-cycle pulse on watchdog expiry
busy  out  1  state != IDLE
sample_count  out  CNT_W  samples written out; saturates
timeout_count  out  CNT_W  watchdog expiries; saturates

Behaviour:

Reset:
- Asynchronous reset forces state IDLE.
- All outputs are 0, including data outputs, counters and the watchdog.
- Reset mid-sample discards the in-flight sample with no write.

State machine: all outputs are registered or decoded directly from state. No combinational path from any input to any output.
- IDLE: if enable && audio_in_available, latch audio_in_L/R into dry registers and go to POP. Otherwise stay.
- POP: read_audio_in=1 for exactly this cycle; latch bypass.
  - bypass=1: out registers <= dry, go to OUT.
  - bypass=0: go to SEND, clear watchdog.
- SEND: fx_in_valid=1; fx_in_L/R = dry registers, held stable.
  - On fx_in_ready=1 this cycle: transfer occurs, go to WAIT_FX.
- WAIT_FX: fx_out_ready=1.
  - On fx_out_valid=1: out registers <= fx_out_L/R, go to OUT.
- Watchdog:
  - Counts every cycle spent in SEND and WAIT_FX, cleared on leaving POP.
  - If the count reaches TIMEOUT_CYCLES-1 while in SEND or WAIT_FX and no handshake completes that cycle, then:
    - out registers <= dry;
    - fx_flush=1 on the next cycle (the first OUT cycle);
    - timeout_count++;
    - go to OUT.
  - A handshake completing on the expiry cycle takes priority: no timeout.
- OUT: wait for audio_out_allowed=1, then go to WR.
- WR: write_audio_out=1 for exactly this cycle; audio_out_L/R hold the out registers. sample_count++. Go to IDLE.

Data and timing rules:
- audio_out_L/R change only on entry to OUT and are stable through WR.
- fx_in_L/R are stable from entry to SEND until the transfer completes.
- Minimum latency from IDLE detect (cycle 0) to the write strobe:
  - bypass: 3 cycles (POP=1, OUT=2, WR=3);
  - effect path with immediate ready/valid: 5 cycles.
- One sample is in flight at a time. The next sample is not considered before the cycle after WR.
- enable deasserted mid-sample does not abort; the current sample completes.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Bypass:
  - Stimulus: enable=1, bypass=1, allowed=1, available pulses with L=0x00001234, R=0xFFFF8000.
  - Required: read_audio_in in cycle 1, write_audio_out in cycle 3, out=(0x00001234, 0xFFFF8000), sample_count=1.
- Effect path:
  - Stimulus: fx_in_ready held 0 for 4 cycles, then 1; fx_out_valid 2 cycles later with (0x11, 0x22).
  - Required: fx_in_L/R stable throughout SEND; output written = (0x11, 0x22); exactly one read and one write strobe.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8, fx_out_valid never asserted.
  - Required: after 8 cycles in SEND+WAIT_FX, fx_flush pulses once, dry sample is written, timeout_count=1.
  - Second variant: fx_out_valid on the expiry cycle → processed sample is written, no flush.
- Output backpressure:
  - Stimulus: audio_out_allowed=0 for 50 cycles.
  - Required: state holds in OUT, no write strobe, audio_out stable; write occurs 1 cycle after allowed rises; no second read strobe meanwhile.
- Reset and enable:
  - Stimulus: assert reset in WAIT_FX.
  - Required: all outputs are 0 immediately (asynchronously), busy=0, no write.
  - Stimulus: enable=0 with available=1.
  - Required: no read strobe.
  - Stimulus: drop enable during SEND.
  - Required: that sample still completes.
- Saturation:
  - Stimulus: CNT_W=2, 5 bypass samples.
  - Required: sample_count sticks at 3.

Source files
------------

// File: rtl/audio_stream_sequencer_if.sv
// Codec FIFO and effect-chain handshake bundle seen by the audio stream sequencer.
// master = sequencer side, slave = codec FIFOs plus effect chain.
interface audio_stream_sequencer_if #(
    parameter int DATA_W = 32
);
    // codec input FIFO
    logic              audio_in_available;
    logic [DATA_W-1:0] audio_in_L;
    logic [DATA_W-1:0] audio_in_R;
    logic              read_audio_in;
    // codec output FIFO
    logic              audio_out_allowed;
    logic              write_audio_out;
    logic [DATA_W-1:0] audio_out_L;
    logic [DATA_W-1:0] audio_out_R;
    // effect chain, dry side
    logic              fx_in_valid;
    logic              fx_in_ready;
    logic [DATA_W-1:0] fx_in_L;
    logic [DATA_W-1:0] fx_in_R;
    // effect chain, wet side
    logic              fx_out_valid;
    logic              fx_out_ready;
    logic [DATA_W-1:0] fx_out_L;
    logic [DATA_W-1:0] fx_out_R;
    logic              fx_flush;

    modport master (
        input  audio_in_available, audio_in_L, audio_in_R,
        output read_audio_in,
        input  audio_out_allowed,
        output write_audio_out, audio_out_L, audio_out_R,
        output fx_in_valid, fx_in_L, fx_in_R,
        input  fx_in_ready,
        input  fx_out_valid, fx_out_L, fx_out_R,
        output fx_out_ready, fx_flush
    );

    modport slave (
        output audio_in_available, audio_in_L, audio_in_R,
        input  read_audio_in,
        output audio_out_allowed,
        input  write_audio_out, audio_out_L, audio_out_R,
        input  fx_in_valid, fx_in_L, fx_in_R,
        output fx_in_ready,
        output fx_out_valid, fx_out_L, fx_out_R,
        input  fx_out_ready, fx_flush
    );
endinterface

// File: rtl/audio_stream_sequencer.sv
// Moves one stereo sample at a time: input FIFO -> effect chain -> output FIFO.
// Bypass skips the effect chain; a watchdog substitutes the dry sample when the
// effect handshake stalls. Every output is a register or a pure state decode.
module audio_stream_sequencer #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     bypass,
    audio_stream_sequencer_if.master bus,
    output logic                     busy,
    output logic [CNT_W-1:0]         sample_count,
    output logic [CNT_W-1:0]         timeout_count
);
    typedef enum logic [2:0] {IDLE, POP, SEND, WAIT_FX, OUT, WR} state_t;

    // watchdog index of the last allowed handshake cycle
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] dry_l, dry_r, out_l, out_r;
    logic [15:0]       wd_cnt;
    logic              fx_flush_q;
    logic              start, in_hs, out_hs, timeout;

    assign start   = (state == IDLE) && enable && bus.audio_in_available;
    assign in_hs   = (state == SEND) && bus.fx_in_ready;
    assign out_hs  = (state == WAIT_FX) && bus.fx_out_valid;
    // >= rather than == so a SEND handshake landing exactly on the last cycle
    // still leaves WAIT_FX guarded (it then needs valid on its first cycle)
    assign timeout = ((state == SEND) || (state == WAIT_FX)) && (wd_cnt >= WD_LAST)
                     && !in_hs && !out_hs;

    // state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state decode; a completing handshake wins over the watchdog
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = POP;
            POP:     state_nxt = bypass ? OUT : SEND;
            SEND:    if (in_hs) state_nxt = WAIT_FX;
                     else if (timeout) state_nxt = OUT;
            WAIT_FX: if (out_hs || timeout) state_nxt = OUT;
            OUT:     if (bus.audio_out_allowed) state_nxt = WR;
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // strobes and handshake flags decoded from state only
    always_comb begin
        bus.read_audio_in   = (state == POP);
        bus.write_audio_out = (state == WR);
        bus.fx_in_valid     = (state == SEND);
        bus.fx_out_ready    = (state == WAIT_FX);
        busy                = (state != IDLE);
    end

    assign bus.fx_in_L     = dry_l;
    assign bus.fx_in_R     = dry_r;
    assign bus.audio_out_L = out_l;
    assign bus.audio_out_R = out_r;
    assign bus.fx_flush    = fx_flush_q;

    // dry sample captured as the FIFO head is detected, held through SEND
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            dry_l <= '0;
            dry_r <= '0;
        end else if (start) begin
            dry_l <= bus.audio_in_L;
            dry_r <= bus.audio_in_R;
        end
    end

    // output sample only changes on the transition into OUT
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            out_l <= '0;
            out_r <= '0;
        end else if (((state == POP) && bypass) || timeout) begin
            out_l <= dry_l;
            out_r <= dry_r;
        end else if (out_hs) begin
            out_l <= bus.fx_out_L;
            out_r <= bus.fx_out_R;
        end
    end

    // watchdog counts SEND+WAIT_FX cycles; flush pulses in the first OUT cycle
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wd_cnt     <= '0;
            fx_flush_q <= 1'b0;
        end else begin
            fx_flush_q <= timeout;
            if (state == POP)
                wd_cnt <= '0;
            else if ((state == SEND) || (state == WAIT_FX))
                wd_cnt <= wd_cnt + 16'd1;
        end
    end

    // saturating status counters
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sample_count  <= '0;
            timeout_count <= '0;
        end else begin
            if ((state == WR) && (sample_count != {CNT_W{1'b1}}))
                sample_count <= sample_count + 1'b1;
            if (timeout && (timeout_count != {CNT_W{1'b1}}))
                timeout_count <= timeout_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Scoreboard bench: the stimulus side predicts each written sample (data, write
// cycle, flush, counters) from the sequencing rules; a monitor checks writes.
module tb_audio_stream_sequencer;
    localparam int DW   = 32;
    localparam int T    = 8;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          cyc;
        int          fl;
        int          sc;
        int          tc;
    } exp_t;

    logic CLOCK_50 = 0;
    logic reset = 1;
    logic enable = 0;
    logic bypass = 0;
    logic busy;
    logic [CW-1:0] sample_count, timeout_count;

    audio_stream_sequencer_if #(.DATA_W(DW)) bus();

    audio_stream_sequencer #(.DATA_W(DW), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .enable        (enable),
        .bypass        (bypass),
        .bus           (bus),
        .busy          (busy),
        .sample_count  (sample_count),
        .timeout_count (timeout_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   expect_read = 0;
    int   n_samp = 0;
    int   n_to = 0;
    exp_t sb[$];
    logic out_phase;

    assign out_phase = busy && !bus.read_audio_in && !bus.fx_in_valid
                       && !bus.fx_out_ready && !bus.write_audio_out;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // monitor: pops the scoreboard on every write strobe
    initial begin
        int   flush_cnt;
        exp_t e;
        flush_cnt = 0;
        forever begin
            @(negedge CLOCK_50);
            if (reset) flush_cnt = 0;
            else begin
                if (bus.fx_flush) flush_cnt++;
                if (bus.read_audio_in && !expect_read) chk("stray_read", 1, 0);
                if (bus.write_audio_out) begin
                    if (sb.size() == 0) chk("stray_write", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("out_L", bus.audio_out_L, e.l);
                        chk("out_R", bus.audio_out_R, e.r);
                        chk("wr_cycle", cyc, e.cyc);
                        chk("flush_pulses", flush_cnt, e.fl);
                        chk("sample_count", sample_count, e.sc);
                        chk("timeout_count", timeout_count, e.tc);
                        flush_cnt = 0;
                    end
                end
            end
        end
    end

    // one sample: bench plays codec FIFOs and the effect chain.
    // d_in: SEND cycles before ready; d_out: WAIT_FX cycles before valid;
    // bp: OUT cycles with allowed low.
    task automatic run_sample(input bit byp, input logic [31:0] l, input logic [31:0] r,
                              input int d_in, input int d_out,
                              input logic [31:0] fl, input logic [31:0] fr,
                              input int bp, input bit drop_en);
        int   k, p, n, j, lim;
        bit   to;
        exp_t e;
        enable = 1;
        bypass = byp;
        bus.audio_in_available = 1;
        bus.audio_in_L = l;
        bus.audio_in_R = r;
        bus.audio_out_allowed = 0;
        expect_read = 1;
        k = 0;
        while (!bus.read_audio_in && k < 20) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk("read_latency", k, 1);
        if (!bus.read_audio_in) begin
            expect_read = 0;
            bus.audio_in_available = 0;
            return;
        end
        p = cyc;
        // reference: handshake index of valid counted from the first SEND cycle;
        // the watchdog fires at index T-1 or the first WAIT_FX cycle, whichever later
        j   = d_in + 1 + d_out;
        lim = (T - 1 > d_in + 1) ? T - 1 : d_in + 1;
        if (byp)            begin n = 0;       to = 0; end
        else if (d_in > T-1) begin n = T;      to = 1; end
        else if (j <= lim)  begin n = j + 1;   to = 0; end
        else                begin n = lim + 1; to = 1; end
        e.l   = (byp || to) ? l : fl;
        e.r   = (byp || to) ? r : fr;
        e.cyc = p + n + bp + 2;
        e.fl  = to ? 1 : 0;
        e.sc  = sat(n_samp);
        n_samp++;
        if (to) n_to++;
        e.tc  = sat(n_to);
        sb.push_back(e);
        // keep the FIFO non-empty to show no second pop happens mid-sample
        bus.audio_in_available = 1'($urandom_range(0, 1));
        bus.audio_in_L = $urandom;
        bus.audio_in_R = $urandom;
        if (drop_en) enable = 0;
        @(negedge CLOCK_50);
        expect_read = 0;
        k = 0;
        while ((bus.fx_in_valid || bus.fx_out_ready) && k < 200) begin
            if (bus.fx_in_valid) begin
                chk("fx_in_L_hold", bus.fx_in_L, l);
                chk("fx_in_R_hold", bus.fx_in_R, r);
            end
            bus.fx_in_ready  = bus.fx_in_valid && (k == d_in);
            bus.fx_out_valid = bus.fx_out_ready && (k == j);
            bus.fx_out_L = fl;
            bus.fx_out_R = fr;
            @(negedge CLOCK_50);
            k++;
        end
        bus.fx_in_ready = 0;
        bus.fx_out_valid = 0;
        chk("fx_cycles", k, n);
        for (int b = 0; b <= bp; b++) begin
            chk("out_state", out_phase, 1);
            chk("out_hold_L", bus.audio_out_L, e.l);
            chk("out_hold_R", bus.audio_out_R, e.r);
            bus.audio_out_allowed = (b == bp);
            @(negedge CLOCK_50);
        end
        chk("write_strobe", bus.write_audio_out, 1);
        bus.audio_in_available = 0;
        bus.audio_out_allowed = 0;
        @(negedge CLOCK_50);
        chk("back_idle", busy, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int cnt;
        bus.audio_in_available = 0;
        bus.audio_in_L = 0;
        bus.audio_in_R = 0;
        bus.audio_out_allowed = 0;
        bus.fx_in_ready = 0;
        bus.fx_out_valid = 0;
        bus.fx_out_L = 0;
        bus.fx_out_R = 0;
        #5;
        chk("rst_data", bus.audio_out_L | bus.audio_out_R | bus.fx_in_L | bus.fx_in_R, 0);
        chk("rst_ctl", {bus.read_audio_in, bus.write_audio_out, bus.fx_in_valid,
                        bus.fx_out_ready, bus.fx_flush, busy, sample_count, timeout_count}, 0);
        repeat (2) @(negedge CLOCK_50);
        reset = 0;
        @(negedge CLOCK_50);

        // directed cases
        run_sample(1, 32'h0000_1234, 32'hFFFF_8000, 0, 0, 0, 0, 0, 0);
        run_sample(0, 32'hA5A5_0001, 32'h5A5A_0002, 4, 2, 32'h11, 32'h22, 0, 0);
        run_sample(0, 32'h0000_0D01, 32'h0000_0D02, 0, 1000, 32'hBAD, 32'hBAD, 1, 0);
        run_sample(0, 32'h0000_0E01, 32'h0000_0E02, 0, T - 2, 32'h33, 32'h44, 0, 0);
        run_sample(0, 32'h0000_0F01, 32'h0000_0F02, T - 1, 0, 32'h55, 32'h66, 0, 0);
        run_sample(0, 32'h0000_0C01, 32'h0000_0C02, 20, 0, 32'hBAD, 32'hBAD, 0, 0);
        run_sample(1, 32'hCAFE_0001, 32'hCAFE_0002, 0, 0, 0, 0, 50, 0);
        run_sample(0, 32'h0000_0B01, 32'h0000_0B02, 3, 1, 32'h77, 32'h88, 2, 1);
        run_sample(0, 32'h0000_0A01, 32'h0000_0A02, 0, 0, 32'h99, 32'hAA, 0, 0);

        // enable low with data available: nothing starts
        enable = 0;
        bus.audio_in_available = 1;
        cnt = 0;
        repeat (10) begin
            @(negedge CLOCK_50);
            if (bus.read_audio_in) cnt++;
        end
        chk("en0_reads", cnt, 0);
        chk("en0_busy", busy, 0);
        bus.audio_in_available = 0;

        // randomized samples
        for (int s = 0; s < 30; s++) begin
            int di, dq, bp;
            di = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 4) : $urandom_range(0, 3);
            dq = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 4) : $urandom_range(0, 3);
            bp = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            run_sample($urandom_range(0, 3) == 0, $urandom, $urandom, di, dq,
                       $urandom, $urandom, bp, 1'($urandom_range(0, 1)));
        end
        chk("final_sample_count", sample_count, sat(n_samp));
        chk("final_timeout_count", timeout_count, sat(n_to));

        // reset while waiting on the effect chain discards the sample
        enable = 1;
        bypass = 0;
        bus.audio_in_available = 1;
        bus.audio_in_L = 32'h1357_9BDF;
        bus.audio_in_R = 32'h2468_ACE0;
        expect_read = 1;
        @(negedge CLOCK_50);
        chk("rst_pop", bus.read_audio_in, 1);
        bus.audio_in_available = 0;
        @(negedge CLOCK_50);
        expect_read = 0;
        bus.fx_in_ready = 1;
        @(negedge CLOCK_50);
        bus.fx_in_ready = 0;
        chk("rst_in_wait", bus.fx_out_ready, 1);
        #2 reset = 1;
        #1;
        chk("arst_data", bus.audio_out_L | bus.audio_out_R | bus.fx_in_L | bus.fx_in_R, 0);
        chk("arst_ctl", {bus.read_audio_in, bus.write_audio_out, bus.fx_in_valid,
                         bus.fx_out_ready, bus.fx_flush, busy, sample_count, timeout_count}, 0);
        sb.delete();
        n_samp = 0;
        n_to = 0;
        repeat (2) @(negedge CLOCK_50);
        reset = 0;
        repeat (5) @(negedge CLOCK_50);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_count", sample_count, 0);
        chk("pending_writes", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
